axi_lite_and_gate: RTL and testbench
====================================

Name: axi_lite_and_gate

Overview:
- AXI4-Lite slave peripheral on the PS GP0 master port, one level below the PS7/interconnect stage that the system bench drives.
- Holds two 32-bit operand registers and produces a registered bitwise AND result.
- Drives the board's 4 LEDs from the low result bits.
- Software writes operands through GP0, reads the result back and sees it on the LEDs.

Parameters:
- ADDR_WIDTH, 8, AXI address bits decoded by the slave; register window is the lowest 16 bytes.
- DATA_WIDTH, 32, AXI data width; fixed at 32, other values unsupported.
- LED_WIDTH, 4, number of LED outputs driven from RESULT[LED_WIDTH-1:0].

Ports:
- ACLK  in  1  system clock; all logic on rising edge.
- ARESETn  in  1  asynchronous active-low reset.
- s_axi_awaddr  in  ADDR_WIDTH  write address.
- s_axi_awvalid  in  1  write address valid.
- s_axi_awready  out  1  write address ready.
- s_axi_wdata  in  32  write data.
- s_axi_wstrb  in  4  byte strobes.
- s_axi_wvalid  in  1  write data valid.
- s_axi_wready  out  1  write data ready.
- s_axi_bresp  out  2  write response.
- s_axi_bvalid  out  1  write response valid.
- s_axi_bready  in  1  write response ready.
- s_axi_araddr  in  ADDR_WIDTH  read address.
- s_axi_arvalid  in  1  read address valid.
- s_axi_arready  out  1  read address ready.
- s_axi_rdata  out  32  read data.
- s_axi_rresp  out  2  read response.
- s_axi_rvalid  out  1  read data valid.
- s_axi_rready  in  1  read data ready.
- leds_o  out  LED_WIDTH  LED drive, active high.

Behaviour:
- Reset (async assert, sync release): all registers, valids and readies 0; bresp = rresp = 00; rdata = 0; leds_o = 0. Any transaction in flight when reset asserts is dropped.
- Register map (byte offsets):
  - 0x00 OPA (RW).
  - 0x04 OPB (RW).
  - 0x08 RESULT (RO; writes ignored with OKAY).
  - 0x0C CTRL (RW): bit0 LED_EN, other bits read 0.
- Addresses >= 0x10: writes ignored, reads return 0, response SLVERR (10). Address bits [1:0] are ignored.
- Write channel FSM, states W_IDLE / W_RESP:
  - In W_IDLE, awready = 1 until AW is captured and wready = 1 until W is captured. AW and W are accepted in either order or in the same cycle.
  - When both are held, the register write commits on that edge, bvalid goes 1 and the FSM enters W_RESP.
  - In W_RESP, awready = wready = 0. bvalid is held until bready; the FSM returns to W_IDLE on the edge where bvalid && bready.
  - Minimum latency is one cycle from the cycle with both AW and W handshakes to bvalid.
- wstrb is honoured per byte; wstrb = 0 commits nothing and returns OKAY.
- Read channel FSM, states R_IDLE / R_DATA:
  - In R_IDLE, arready = 1. An AR handshake captures the address and registers rdata/rresp; rvalid goes 1 the next cycle.
  - In R_DATA, arready = 0. rdata/rresp stay stable until rready; the FSM returns to R_IDLE on the edge where rvalid && rready.
- The read and write FSMs are independent. If a read's AR handshake happens on the same edge as a write commit, the read returns the pre-write value.
- RESULT <= OPA & OPB, registered: it updates on the edge after an operand commit.
- leds_o = LED_EN ? RESULT[LED_WIDTH-1:0] : 0. leds_o is registered, so it lags RESULT by one cycle.

Optional Feature:
- Macro: AND_GATE_IRQ_EN.
- Defined:
  - Adds output irq_o (1 bit, reset 0) and STATUS register 0x10 (bit0 RES_CHG, write-1-to-clear), so the valid window extends to 0x14.
  - RES_CHG sets on any cycle where RESULT changes value; irq_o = RES_CHG & CTRL bit1 (IRQ_EN).
  - Set and clear in the same cycle: set wins.
- Not defined: no irq_o port; 0x10 returns SLVERR; CTRL bit1 reads 0.

Test Plan:
- Reset mid-write: assert ARESETn = 0 while bvalid = 1 -> bvalid, leds_o and all registers 0 immediately; FSM in W_IDLE after release.
- Write OPA = 0xDEADBEEF, OPB = 0xFFFF00FF, CTRL = 0x1 -> read 0x08 returns 0xDEAD00EF with rresp = 00; leds_o = 0xF two cycles after the OPB commit.
- Write W before AW (W 3 cycles early) with wstrb = 0x2, data 0x0000AB00 to OPA = 0 -> OPA = 0x0000AB00, single bvalid pulse, bresp = 00.
- Hold bready = 0 for 5 cycles -> bvalid stays 1, awready and wready stay 0; the next write is accepted only after the handshake.
- Read 0x20, and write 0x24 with 0x12345678 -> rdata = 0, rresp = 10; bresp = 10; OPA/OPB/CTRL unchanged.
- With AND_GATE_IRQ_EN, CTRL = 0x3, change OPB -> irq_o = 1; write 0x1 to 0x10 -> irq_o = 0 next cycle.

Source files
------------

// File: rtl/axi_lite_and_gate.sv
// AXI4-Lite AND-gate peripheral: OPA/OPB operands, registered RESULT = OPA & OPB, CTRL LED enable; `AND_GATE_IRQ_EN adds STATUS and irq_o.
// Latency: B one cycle after AW+W, R one cycle after AR; each channel holds its ready low until its response handshakes.
module axi_lite_and_gate #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int LED_WIDTH  = 4
) (
  input  logic                    ACLK,
  input  logic                    ARESETn,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic [LED_WIDTH-1:0]    leds_o
`ifdef AND_GATE_IRQ_EN
  ,
  output logic                    irq_o
`endif
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AND_GATE_IRQ_EN
  localparam logic [ADDR_WIDTH-1:0] WIN_END = ADDR_WIDTH'(20);
`else
  localparam logic [ADDR_WIDTH-1:0] WIN_END = ADDR_WIDTH'(16);
`endif
  localparam logic [2:0] IDX_OPA    = 3'd0;
  localparam logic [2:0] IDX_OPB    = 3'd1;
  localparam logic [2:0] IDX_RESULT = 3'd2;
  localparam logic [2:0] IDX_CTRL   = 3'd3;
  localparam logic [2:0] IDX_STATUS = 3'd4;

  typedef enum logic {W_IDLE, W_RESP} w_state_e;
  typedef enum logic {R_IDLE, R_DATA} r_state_e;

  function automatic logic [DATA_WIDTH-1:0] merge_bytes(
    input logic [DATA_WIDTH-1:0] old_val,
    input logic [DATA_WIDTH-1:0] new_val,
    input logic [STRB_WIDTH-1:0] strb
  );
    logic [DATA_WIDTH-1:0] r;
    r = old_val;
    for (int b = 0; b < STRB_WIDTH; b++) begin
      if (strb[b]) r[8*b +: 8] = new_val[8*b +: 8];
    end
    return r;
  endfunction

  // Register file
  logic [DATA_WIDTH-1:0] opa, opb, result;
  logic                  led_en;
  logic                  irq_en;
  logic                  res_chg;
  logic [DATA_WIDTH-1:0] ctrl_rd;

  // Readies stay low while reset is asserted and for the first cycle after release.
  logic rdy_en;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // ---------------- Write channel ----------------
  w_state_e              w_state, w_state_nxt;
  logic                  aw_held, w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_WIDTH-1:0] wstrb_q;
  logic [1:0]            bresp_q;

  logic                  aw_hs, w_hs, wr_commit, wr_ok;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_WIDTH-1:0] wr_strb;
  logic [2:0]            wr_idx;

  assign aw_hs     = s_axi_awvalid && s_axi_awready;
  assign w_hs      = s_axi_wvalid && s_axi_wready;
  // A channel captured in an earlier cycle is taken from its holding register.
  assign wr_addr   = aw_held ? aw_addr_q : s_axi_awaddr;
  assign wr_data   = w_held ? wdata_q : s_axi_wdata;
  assign wr_strb   = w_held ? wstrb_q : s_axi_wstrb;
  assign wr_commit = (w_state == W_IDLE) && (aw_held || aw_hs) && (w_held || w_hs);
  assign wr_ok     = wr_addr < WIN_END;
  assign wr_idx    = wr_addr[4:2];

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) w_state <= W_IDLE;
    else          w_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:  if (wr_commit) w_state_nxt = W_RESP;
      W_RESP:  if (s_axi_bvalid && s_axi_bready) w_state_nxt = W_IDLE;
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = rdy_en && (w_state == W_IDLE) && !aw_held;
    s_axi_wready  = rdy_en && (w_state == W_IDLE) && !w_held;
    s_axi_bvalid  = (w_state == W_RESP);
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bresp_q   <= RESP_OKAY;
    end else if (wr_commit) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      bresp_q <= wr_ok ? RESP_OKAY : RESP_SLVERR;
    end else begin
      if (aw_hs) begin
        aw_held   <= 1'b1;
        aw_addr_q <= s_axi_awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s_axi_wdata;
        wstrb_q <= s_axi_wstrb;
      end
    end
  end

  assign s_axi_bresp = bresp_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      opa    <= '0;
      opb    <= '0;
      led_en <= 1'b0;
      irq_en <= 1'b0;
    end else if (wr_commit && wr_ok) begin
      case (wr_idx)
        IDX_OPA: opa <= merge_bytes(opa, wr_data, wr_strb);
        IDX_OPB: opb <= merge_bytes(opb, wr_data, wr_strb);
        IDX_CTRL: begin
          if (wr_strb[0]) begin
            led_en <= wr_data[0];
`ifdef AND_GATE_IRQ_EN
            irq_en <= wr_data[1];
`endif
          end
        end
        default: ;
      endcase
    end
  end

  // RESULT trails an operand commit by one edge and the LEDs trail RESULT by one more.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      result <= '0;
      leds_o <= '0;
    end else begin
      result <= opa & opb;
      leds_o <= led_en ? result[LED_WIDTH-1:0] : '0;
    end
  end

`ifdef AND_GATE_IRQ_EN
  logic res_set, res_clr;

  assign res_set = (opa & opb) != result;
  assign res_clr = wr_commit && wr_ok && (wr_idx == IDX_STATUS) && wr_strb[0] && wr_data[0];

  // A new change arriving with the clear keeps the flag set.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)     res_chg <= 1'b0;
    else if (res_set) res_chg <= 1'b1;
    else if (res_clr) res_chg <= 1'b0;
  end

  assign irq_o   = res_chg && irq_en;
  assign ctrl_rd = {{(DATA_WIDTH-2){1'b0}}, irq_en, led_en};
`else
  assign res_chg = 1'b0;
  assign ctrl_rd = {{(DATA_WIDTH-1){1'b0}}, led_en};
`endif

  // ---------------- Read channel ----------------
  r_state_e              r_state, r_state_nxt;
  logic                  ar_hs, rd_ok;
  logic [DATA_WIDTH-1:0] rd_word, rdata_q;
  logic [1:0]            rresp_q;

  assign ar_hs = s_axi_arvalid && s_axi_arready;
  assign rd_ok = s_axi_araddr < WIN_END;

  always_comb begin
    rd_word = '0;
    if (rd_ok) begin
      case (s_axi_araddr[4:2])
        IDX_OPA:    rd_word = opa;
        IDX_OPB:    rd_word = opb;
        IDX_RESULT: rd_word = result;
        IDX_CTRL:   rd_word = ctrl_rd;
        IDX_STATUS: rd_word = {{(DATA_WIDTH-1){1'b0}}, res_chg};
        default:    rd_word = '0;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) r_state <= R_IDLE;
    else          r_state <= r_state_nxt;
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
      R_DATA:  if (s_axi_rvalid && s_axi_rready) r_state_nxt = R_IDLE;
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_arready = rdy_en && (r_state == R_IDLE);
    s_axi_rvalid  = (r_state == R_DATA);
  end

  // Read data is sampled from the registers before any write committing on the same edge.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rdata_q <= '0;
      rresp_q <= RESP_OKAY;
    end else if (ar_hs) begin
      rdata_q <= rd_word;
      rresp_q <= rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
  end

  assign s_axi_rdata = rdata_q;
  assign s_axi_rresp = rresp_q;

endmodule

// File: tb/tb_axi_lite_and_gate.sv
// Directed bench for axi_lite_and_gate: register-map vector table plus hand sequences for handshake timing and reset.
module tb_axi_lite_and_gate;

  logic        tb_ACLK = 1'b0;
  logic        tb_ARESETn;
  logic [7:0]  s_axi_awaddr;
  logic        s_axi_awvalid;
  logic        s_axi_awready;
  logic [31:0] s_axi_wdata;
  logic [3:0]  s_axi_wstrb;
  logic        s_axi_wvalid;
  logic        s_axi_wready;
  logic [1:0]  s_axi_bresp;
  logic        s_axi_bvalid;
  logic        s_axi_bready;
  logic [7:0]  s_axi_araddr;
  logic        s_axi_arvalid;
  logic        s_axi_arready;
  logic [31:0] s_axi_rdata;
  logic [1:0]  s_axi_rresp;
  logic        s_axi_rvalid;
  logic        s_axi_rready;
  logic [3:0]  leds_o;
`ifdef AND_GATE_IRQ_EN
  logic        irq_o;
`endif

  always #5 tb_ACLK = ~tb_ACLK;

  axi_lite_and_gate dut (
    .ACLK          (tb_ACLK),
    .ARESETn       (tb_ARESETn),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready),
    .leds_o        (leds_o)
`ifdef AND_GATE_IRQ_EN
    ,
    .irq_o         (irq_o)
`endif
  );

  typedef struct {
    bit          wr;
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  exp_resp;
    logic [31:0] exp_rdata;
    string       name;
  } vec_t;

  vec_t        vecs[$];
  int          checks = 0;
  int          failures = 0;
  logic [1:0]  resp;
  logic [31:0] rd;

  function automatic vec_t mk(input bit wr, input logic [7:0] a, input logic [31:0] d,
                              input logic [3:0] s, input logic [1:0] er, input logic [31:0] ed,
                              input string n);
    vec_t v;
    v.wr = wr; v.addr = a; v.data = d; v.strb = s;
    v.exp_resp = er; v.exp_rdata = ed; v.name = n;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL %s: timed out waiting for handshake", name);
  endtask

  task automatic tick();
    @(posedge tb_ACLK);
    #1;
  endtask

  task automatic axi_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] r);
    bit aw_done, w_done, aw_go, w_go;
    int n;
    s_axi_awaddr = a; s_axi_awvalid = 1'b1;
    s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b1;
    aw_done = 0; w_done = 0; n = 0; r = 2'bxx;
    while (!(aw_done && w_done) && n < 20) begin
      @(negedge tb_ACLK);
      aw_go = s_axi_awvalid && s_axi_awready;
      w_go  = s_axi_wvalid && s_axi_wready;
      tick();
      if (aw_go) begin s_axi_awvalid = 1'b0; aw_done = 1; end
      if (w_go)  begin s_axi_wvalid = 1'b0;  w_done = 1;  end
      n++;
    end
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    if (!(aw_done && w_done)) timeout("write addr/data");
    n = 0;
    while (n < 20) begin
      @(negedge tb_ACLK);
      if (s_axi_bvalid) begin
        r = s_axi_bresp;
        break;
      end
      n++;
    end
    if (n == 20) timeout("write resp");
    tick();
    s_axi_bready = 1'b0;
  endtask

  task automatic axi_read(input logic [7:0] a, output logic [31:0] d, output logic [1:0] r);
    int n;
    bit go;
    s_axi_araddr = a; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    d = 'x; r = 2'bxx; n = 0; go = 0;
    while (!go && n < 20) begin
      @(negedge tb_ACLK);
      go = s_axi_arready;
      tick();
      n++;
    end
    s_axi_arvalid = 1'b0;
    if (!go) timeout("read addr");
    n = 0;
    while (n < 20) begin
      @(negedge tb_ACLK);
      if (s_axi_rvalid) begin
        d = s_axi_rdata;
        r = s_axi_rresp;
        break;
      end
      n++;
    end
    if (n == 20) timeout("read data");
    tick();
    s_axi_rready = 1'b0;
  endtask

  initial begin
    int bad;
    int pulses;

    tb_ARESETn = 1'b0;
    s_axi_awaddr = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
    s_axi_araddr = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;

    // Table: main function, strobes, RO RESULT, ignored addr[1:0], out-of-window accesses
    vecs.push_back(mk(1, 8'h00, 32'hDEADBEEF, 4'hF, 2'b00, 32'h0, "wr OPA"));
    vecs.push_back(mk(1, 8'h04, 32'hFFFF00FF, 4'hF, 2'b00, 32'h0, "wr OPB"));
    vecs.push_back(mk(1, 8'h0C, 32'h00000001, 4'hF, 2'b00, 32'h0, "wr CTRL"));
    vecs.push_back(mk(0, 8'h08, 32'h0, 4'h0, 2'b00, 32'hDEAD00EF, "rd RESULT"));
    vecs.push_back(mk(0, 8'h00, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, "rd OPA"));
    vecs.push_back(mk(0, 8'h04, 32'h0, 4'h0, 2'b00, 32'hFFFF00FF, "rd OPB"));
    vecs.push_back(mk(0, 8'h0C, 32'h0, 4'h0, 2'b00, 32'h00000001, "rd CTRL"));
    vecs.push_back(mk(1, 8'h08, 32'h12345678, 4'hF, 2'b00, 32'h0, "wr RESULT ro"));
    vecs.push_back(mk(0, 8'h08, 32'h0, 4'h0, 2'b00, 32'hDEAD00EF, "rd RESULT kept"));
    vecs.push_back(mk(0, 8'h0B, 32'h0, 4'h0, 2'b00, 32'hDEAD00EF, "rd RESULT low bits"));
    vecs.push_back(mk(1, 8'h04, 32'h000000AA, 4'h0, 2'b00, 32'h0, "wr OPB strb0"));
    vecs.push_back(mk(0, 8'h04, 32'h0, 4'h0, 2'b00, 32'hFFFF00FF, "rd OPB strb0"));
    vecs.push_back(mk(1, 8'h04, 32'h000000AA, 4'h1, 2'b00, 32'h0, "wr OPB byte0"));
    vecs.push_back(mk(0, 8'h04, 32'h0, 4'h0, 2'b00, 32'hFFFF00AA, "rd OPB byte0"));
    vecs.push_back(mk(0, 8'h08, 32'h0, 4'h0, 2'b00, 32'hDEAD00AA, "rd RESULT byte0"));
    vecs.push_back(mk(0, 8'h20, 32'h0, 4'h0, 2'b10, 32'h00000000, "rd 0x20"));
    vecs.push_back(mk(1, 8'h24, 32'h12345678, 4'hF, 2'b10, 32'h0, "wr 0x24"));
    vecs.push_back(mk(0, 8'h00, 32'h0, 4'h0, 2'b00, 32'hDEADBEEF, "rd OPA after 0x24"));
    vecs.push_back(mk(0, 8'h04, 32'h0, 4'h0, 2'b00, 32'hFFFF00AA, "rd OPB after 0x24"));
    vecs.push_back(mk(0, 8'h0C, 32'h0, 4'h0, 2'b00, 32'h00000001, "rd CTRL after 0x24"));
`ifndef AND_GATE_IRQ_EN
    vecs.push_back(mk(0, 8'h10, 32'h0, 4'h0, 2'b10, 32'h00000000, "rd 0x10"));
    vecs.push_back(mk(1, 8'h10, 32'h00000001, 4'hF, 2'b10, 32'h0, "wr 0x10"));
    vecs.push_back(mk(1, 8'h0C, 32'h00000003, 4'hF, 2'b00, 32'h0, "wr CTRL 3"));
    vecs.push_back(mk(0, 8'h0C, 32'h0, 4'h0, 2'b00, 32'h00000001, "rd CTRL bit1"));
`endif

    // Reset state
    #12;
    check("rst awready", 32'(s_axi_awready), 32'h0);
    check("rst wready",  32'(s_axi_wready),  32'h0);
    check("rst arready", 32'(s_axi_arready), 32'h0);
    check("rst bvalid",  32'(s_axi_bvalid),  32'h0);
    check("rst rvalid",  32'(s_axi_rvalid),  32'h0);
    check("rst bresp",   32'(s_axi_bresp),   32'h0);
    check("rst rresp",   32'(s_axi_rresp),   32'h0);
    check("rst rdata",   s_axi_rdata,        32'h0);
    check("rst leds",    32'(leds_o),        32'h0);
    @(negedge tb_ACLK);
    tb_ARESETn = 1'b1;
    tick(); tick();

    foreach (vecs[i]) begin
      if (vecs[i].wr) begin
        axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, resp);
        check({vecs[i].name, " bresp"}, 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        axi_read(vecs[i].addr, rd, resp);
        check({vecs[i].name, " rresp"}, 32'(resp), 32'(vecs[i].exp_resp));
        check({vecs[i].name, " rdata"}, rd, vecs[i].exp_rdata);
      end
    end
    check("leds after table", 32'(leds_o), 32'hA);

    // LED timing: AW and W together, LEDs follow two edges after the commit
    s_axi_awaddr = 8'h04; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hFFFF00FF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b0;
    @(negedge tb_ACLK);
    check("led seq aw+w ready", 32'({s_axi_awready, s_axi_wready}), 32'h3);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("led seq bvalid min latency", 32'(s_axi_bvalid), 32'h1);
    check("leds at commit+0", 32'(leds_o), 32'hA);
    tick();
    check("leds at commit+1", 32'(leds_o), 32'hA);
    tick();
    check("leds at commit+2", 32'(leds_o), 32'hF);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("led seq bvalid cleared", 32'(s_axi_bvalid), 32'h0);
    axi_read(8'h08, rd, resp);
    check("led seq RESULT", rd, 32'hDEAD00EF);

    // W three cycles ahead of AW, single strobe byte
    axi_write(8'h00, 32'h0, 4'hF, resp);
    check("clear OPA bresp", 32'(resp), 32'h0);
    s_axi_wdata = 32'h0000AB00; s_axi_wstrb = 4'h2; s_axi_wvalid = 1'b1;
    @(negedge tb_ACLK);
    check("early W wready", 32'(s_axi_wready), 32'h1);
    tick();
    s_axi_wvalid = 1'b0;
    bad = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge tb_ACLK);
      if (s_axi_wready || s_axi_bvalid || !s_axi_awready) bad++;
      tick();
    end
    check("early W held, no bvalid", 32'(bad), 32'h0);
    s_axi_awaddr = 8'h00; s_axi_awvalid = 1'b1; s_axi_bready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    pulses = 0;
    resp = 2'bxx;
    for (int k = 0; k < 6; k++) begin
      @(negedge tb_ACLK);
      if (s_axi_bvalid) begin pulses++; resp = s_axi_bresp; end
    end
    s_axi_bready = 1'b0;
    check("early W bvalid pulses", 32'(pulses), 32'h1);
    check("early W bresp", 32'(resp), 32'h0);
    axi_read(8'h00, rd, resp);
    check("early W OPA", rd, 32'h0000AB00);

    // bready held low: channel blocks the next write until the B handshake
    s_axi_awaddr = 8'h0C; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_bready = 1'b0;
    tick();
    s_axi_awaddr = 8'h04; s_axi_wdata = 32'h0F0F0F0F;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge tb_ACLK);
      if (!s_axi_bvalid || s_axi_awready || s_axi_wready) bad++;
    end
    check("bready low: stall", 32'(bad), 32'h0);
    s_axi_bready = 1'b1;
    tick();
    check("bready low: B done", 32'(s_axi_bvalid), 32'h0);
    @(negedge tb_ACLK);
    check("bready low: readies back", 32'({s_axi_awready, s_axi_wready}), 32'h3);
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("bready low: 2nd write bvalid", 32'(s_axi_bvalid), 32'h1);
    tick();
    s_axi_bready = 1'b0;
    axi_read(8'h04, rd, resp);
    check("bready low: OPB", rd, 32'h0F0F0F0F);

    // Read and write committing on the same edge: read sees the old value
    s_axi_awaddr = 8'h00; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h11111111; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
    s_axi_araddr = 8'h00; s_axi_arvalid = 1'b1;
    s_axi_bready = 1'b1; s_axi_rready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge tb_ACLK);
    check("same-edge rvalid", 32'(s_axi_rvalid), 32'h1);
    check("same-edge rdata old", s_axi_rdata, 32'h0000AB00);
    check("same-edge bvalid", 32'(s_axi_bvalid), 32'h1);
    tick();
    s_axi_bready = 1'b0; s_axi_rready = 1'b0;
    axi_read(8'h00, rd, resp);
    check("same-edge OPA new", rd, 32'h11111111);
    check("leds before reset", 32'(leds_o), 32'h1);

    // Reset while bvalid is pending
    s_axi_awaddr = 8'h04; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'hFFFFFFFF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b0;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("pre-reset bvalid", 32'(s_axi_bvalid), 32'h1);
    #2;
    tb_ARESETn = 1'b0;
    #1;
    check("mid reset bvalid", 32'(s_axi_bvalid), 32'h0);
    check("mid reset leds", 32'(leds_o), 32'h0);
    check("mid reset readies", 32'({s_axi_awready, s_axi_wready, s_axi_arready}), 32'h0);
    @(negedge tb_ACLK);
    tb_ARESETn = 1'b1;
    tick(); tick();
    check("post reset W_IDLE", 32'({s_axi_awready, s_axi_wready, s_axi_bvalid}), 32'h6);
    axi_read(8'h00, rd, resp);
    check("post reset OPA", rd, 32'h0);
    axi_read(8'h04, rd, resp);
    check("post reset OPB", rd, 32'h0);
    axi_read(8'h08, rd, resp);
    check("post reset RESULT", rd, 32'h0);
    axi_read(8'h0C, rd, resp);
    check("post reset CTRL", rd, 32'h0);

`ifdef AND_GATE_IRQ_EN
    axi_write(8'h00, 32'h000000FF, 4'hF, resp);
    axi_write(8'h0C, 32'h00000003, 4'hF, resp);
    axi_read(8'h0C, rd, resp);
    check("irq CTRL readback", rd, 32'h3);
    axi_write(8'h10, 32'h00000001, 4'hF, resp);
    check("irq STATUS wr bresp", 32'(resp), 32'h0);
    check("irq after clear", 32'(irq_o), 32'h0);
    axi_write(8'h04, 32'h000000F0, 4'hF, resp);
    check("irq on OPB change", 32'(irq_o), 32'h1);
    axi_read(8'h10, rd, resp);
    check("irq STATUS rresp", 32'(resp), 32'h0);
    check("irq STATUS RES_CHG", rd, 32'h1);
    s_axi_awaddr = 8'h10; s_axi_awvalid = 1'b1;
    s_axi_wdata = 32'h1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
    check("irq cleared next cycle", 32'(irq_o), 32'h0);
    tick();
    s_axi_bready = 1'b0;
    axi_write(8'h0C, 32'h00000001, 4'hF, resp);
    axi_write(8'h04, 32'h0000000F, 4'hF, resp);
    check("irq masked", 32'(irq_o), 32'h0);
    axi_read(8'h10, rd, resp);
    check("irq masked STATUS", rd, 32'h1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
